aes_key_expand: RTL and testbench

- Iterative AES-128 key-schedule engine.
- Accepts a 128-bit cipher key over a valid/ready handshake and streams round keys 0..NROUNDS, one per accepted transfer, to the downstream round datapath.
- Instantiates four sbox ROMs for SubWord and one rcon ROM, and computes each next round key from the current one in a single cycle.

---
 rtl/aes_key_expand.sv | 143 ++++++++++++++
 tb/tb_aes_key_expand.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts a cipher key and streams round keys
// 0..NROUNDS over a valid/ready interface, one next-key step per accepted transfer.
module aes_key_expand #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned RW = 4;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] i);
    logic [7:0] v;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_cur_key, w_key_nxt;
  logic [RW-1:0]   r_round, w_round_nxt;
  logic            r_key_ready, w_key_ready_nxt;
  logic            r_rk_valid, w_rk_valid_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;

  logic [WW-1:0]   w_rot, w_sub, w_t;
  logic [WW-1:0]   w_w4, w_w5, w_w6, w_w7;
  logic [7:0]      w_rcon;
  logic [KW-1:0]   w_next_key;

  // One key-schedule step: four SubWord lookups on the rotated last word.
  always_comb begin
    w_rot      = {r_cur_key[23:0], r_cur_key[31:24]};
    w_sub      = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    w_rcon     = rcon(RW'(r_round + 4'd1));
    w_t        = w_sub ^ {w_rcon, 24'h000000};
    w_w4       = r_cur_key[127:96] ^ w_t;
    w_w5       = r_cur_key[95:64]  ^ w_w4;
    w_w6       = r_cur_key[63:32]  ^ w_w5;
    w_w7       = r_cur_key[31:0]   ^ w_w6;
    w_next_key = {w_w4, w_w5, w_w6, w_w7};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_cur_key;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_valid && r_key_ready) begin
          w_key_nxt   = key_in;
          w_round_nxt = '0;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (r_round < RW'(NROUNDS)) begin
            w_key_nxt   = w_next_key;
            w_round_nxt = RW'(r_round + 4'd1);
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_key_ready_nxt = (w_state_nxt == S_IDLE);
    w_rk_valid_nxt  = (w_state_nxt == S_EMIT);
    w_busy_nxt      = (w_state_nxt == S_EMIT);
  end

  // key_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_key   <= '0;
      r_round     <= '0;
      r_key_ready <= 1'b0;
      r_rk_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_key   <= w_key_nxt;
      r_round     <= w_round_nxt;
      r_key_ready <= w_key_ready_nxt;
      r_rk_valid  <= w_rk_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign key_ready = r_key_ready;
  assign rk_valid  = r_rk_valid;
  assign rk_out    = r_cur_key;
  assign rk_index  = r_round;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197-style key expansion model (GF(2^8) S-box)
// driving a per-cycle scoreboard, plus directed literal checks.
module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk, rst_n;
  logic         key_valid, key_ready, rk_valid, rk_ready, busy, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_index;

  logic         n1_valid, n1_ready, n1_rk_valid, n1_rk_ready, n1_busy, n1_done;
  logic [127:0] n1_in, n1_rk_out;
  logic [3:0]   n1_rk_index;

  int n_chk = 0;
  int n_pass = 0;

  aes_key_expand u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_index(rk_index), .busy(busy), .done(done)
  );

  aes_key_expand #(.NROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_valid(n1_valid), .key_ready(n1_ready),
    .key_in(n1_in), .rk_valid(n1_rk_valid), .rk_ready(n1_rk_ready), .rk_out(n1_rk_out),
    .rk_index(n1_rk_index), .busy(n1_busy), .done(n1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] p = 8'h01;
    logic [7:0] b = a;
    logic [7:0] s;
    int e = 254;
    while (e != 0) begin
      if (e % 2 == 1) p = gmul(p, b);
      b = gmul(b, b);
      e = e / 2;
    end
    s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rc(input int i);
    logic [7:0] x = 8'h01;
    for (int k = 1; k < i; k++) x = xtime(x);
    return x;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc(i/4), 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- scoreboard on main DUT ----------------
  logic [127:0] exp_q[$];
  logic         m_ready = 1'b0;
  logic         m_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_done  = 1'b0;
      chk("rst_key_ready", 128'(key_ready), 128'(0));
      chk("rst_rk_valid", 128'(rk_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rk_out", rk_out, 128'(0));
      chk("rst_rk_index", 128'(rk_index), 128'(0));
    end else begin
      chk("sb_key_ready", 128'(key_ready), 128'(m_ready));
      chk("sb_rk_valid", 128'(rk_valid), 128'(exp_q.size() != 0));
      chk("sb_busy", 128'(busy), 128'(exp_q.size() != 0));
      chk("sb_done", 128'(done), 128'(m_done));
      if (exp_q.size() != 0) begin
        chk("sb_rk_out", rk_out, exp_q[0]);
        chk("sb_rk_index", 128'(rk_index), 128'(11 - exp_q.size()));
      end
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
        if (rk_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_done  = 1'b1;
            m_ready = 1'b1;
          end
        end
      end else if (m_ready && key_valid) begin
        for (int r = 0; r <= 10; r++) exp_q.push_back(round_key(key_in, r));
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_key(input logic [127:0] k, input logic [127:0] e1,
                         input logic [127:0] e10, input string tag);
    key_valid = 1'b1;
    key_in    = k;
    rk_ready  = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk({tag, "_idx"}, 128'(rk_index), 128'(i));
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      if (i == 0)  chk({tag, "_rk0"}, rk_out, k);
      if (i == 1)  chk({tag, "_rk1"}, rk_out, e1);
      if (i == 10) chk({tag, "_rk10"}, rk_out, e10);
      step();
    end
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_ready_at_done"}, 128'(key_ready), 128'(1));
    step();
    chk({tag, "_done_low"}, 128'(done), 128'(0));
  endtask

  initial begin
    int hs;
    int cyc;
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    n1_valid = 1'b0; n1_in = '0; n1_rk_ready = 1'b0;

    chk("model_fips_r1", round_key(FIPS_KEY, 1), FIPS_R1);
    chk("model_fips_r10", round_key(FIPS_KEY, 10), FIPS_R10);
    chk("model_zero_r1", round_key(128'h0, 1), ZERO_R1);
    chk("model_zero_r10", round_key(128'h0, 10), ZERO_R10);

    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 128'(key_ready), 128'(1));

    // 1, 2: full-rate streams
    run_key(FIPS_KEY, FIPS_R1, FIPS_R10, "t1");
    run_key(128'h0, ZERO_R1, ZERO_R10, "t2");

    // 3: random backpressure
    key_valid = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b0;
    step();
    key_valid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 11 && cyc < 500) begin
      rk_ready = 1'($urandom_range(0, 1));
      cyc++;
      @(posedge clk);
      if (rk_ready) hs++;
      #1;
    end
    chk("t3_handshakes", 128'(hs), 128'(11));
    chk("t3_done", 128'(done), 128'(1));
    rk_ready = 1'b1;
    step();

    // 4: reset mid-stream at idx5
    key_valid = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (5) step();
    chk("t4_idx5", 128'(rk_index), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("t4_valid_drop", 128'(rk_valid), 128'(0));
    chk("t4_busy_drop", 128'(busy), 128'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("t4_ready", 128'(key_ready), 128'(1));
    run_key(128'h0, ZERO_R1, ZERO_R10, "t4");

    // 5: key_valid held during EMIT; second key captured in the done cycle
    key_valid = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
    step();
    for (int i = 0; i <= 10; i++) begin
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("t5_ready_low", 128'(key_ready), 128'(0));
      chk("t5_idx", 128'(rk_index), 128'(i));
      step();
    end
    key_in = 128'h0;
    chk("t5_done", 128'(done), 128'(1));
    chk("t5_ready", 128'(key_ready), 128'(1));
    step();
    key_valid = 1'b0;
    chk("t5_new_valid", 128'(rk_valid), 128'(1));
    chk("t5_new_idx0", 128'(rk_index), 128'(0));
    chk("t5_new_rk0", rk_out, 128'h0);
    repeat (11) step();
    chk("t5_new_done", 128'(done), 128'(1));
    step();

    // 6: NROUNDS=1 instance
    chk("t6_ready", 128'(n1_ready), 128'(1));
    n1_valid = 1'b1; n1_in = FIPS_KEY; n1_rk_ready = 1'b1;
    step();
    n1_valid = 1'b0;
    chk("t6_valid0", 128'(n1_rk_valid), 128'(1));
    chk("t6_idx0", 128'(n1_rk_index), 128'(0));
    chk("t6_rk0", n1_rk_out, FIPS_KEY);
    step();
    chk("t6_idx1", 128'(n1_rk_index), 128'(1));
    chk("t6_rk1", n1_rk_out, FIPS_R1);
    step();
    chk("t6_valid_end", 128'(n1_rk_valid), 128'(0));
    chk("t6_done", 128'(n1_done), 128'(1));
    chk("t6_ready_end", 128'(n1_ready), 128'(1));
    step();
    chk("t6_done_low", 128'(n1_done), 128'(0));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
